spi_frame_rx: RTL

Synchronous SPI slave receiver that deserializes the `Cs_n`/`Clk_out`/`MOSI` stream produced by the ADC capture top's serial output port. It runs on the system clock, oversamples the three serial lines, and recovers MSB-first data words with per-word valid strobes and per-frame status. It is used on the receiving FPGA and as an on-chip loopback checker for the ADC serial link.

---
 rtl/spi_frame_rx_pkg.sv | 15 +
 rtl/spi_frame_rx_sync_edge.sv | 32 +++
 rtl/spi_frame_rx.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/spi_frame_rx_pkg.sv
// Shared types and default parameters for the SPI frame receiver.
// The state enum is also exported on the debug port of the top.
package spi_rx_pkg;

   localparam int DATA_W_DEF      = 16;
   localparam int SYNC_STAGES_DEF = 2;
   localparam int CNT_W_DEF       = 8;

   typedef enum logic [1:0] {
      WAIT_IDLE = 2'd0,
      IDLE      = 2'd1,
      SHIFT     = 2'd2
   } state_e;

endpackage

// File: rtl/spi_frame_rx_sync_edge.sv
// Multi-flop synchronizer plus one history flop.
// Provides the synchronized level and single-cycle rise/fall flags.
module sync_edge #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              hist;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         chain <= {STAGES{RST_VAL}};
         hist  <= RST_VAL;
      end else begin
         chain <= {chain[STAGES-2:0], d};
         hist  <= chain[STAGES-1];
      end
   end

   assign level = chain[STAGES-1];
   assign rise  = level & ~hist;
   assign fall  = ~level & hist;

endmodule

// File: rtl/spi_frame_rx.sv
// SPI mode-0 slave receiver running on the system clock: oversamples Cs_n/Sclk/MOSI,
// assembles MSB-first words and reports per-frame word count and partial-word errors.
module spi_frame_rx
   import spi_rx_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int CNT_W       = CNT_W_DEF
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              Cs_n,
   input  logic              Sclk,
   input  logic              MOSI,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              frame_done,
   output logic [CNT_W-1:0]  frame_words,
   output logic              frame_err,
   output state_e            dbg_state
);

   localparam int BIT_W    = (DATA_W > 2) ? $clog2(DATA_W) : 1;
   localparam int SETTLE   = SYNC_STAGES + 1;
   localparam int SETTLE_W = $clog2(SETTLE + 1);

   // Outputs: data_valid is a one-cycle strobe with data_out valid in that cycle and
   // held afterwards; there is no back-pressure, the consumer must take it then.
   // frame_done likewise qualifies frame_words and frame_err in its cycle.

   logic cs_level, cs_rise, cs_fall;
   logic sclk_level, sclk_rise, sclk_fall;
   logic mosi_s, mosi_rise, mosi_fall;

   sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .clk   (Clk),
      .rst_n (Rst_n),
      .d     (Cs_n),
      .level (cs_level),
      .rise  (cs_rise),
      .fall  (cs_fall)
   );

   sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk   (Clk),
      .rst_n (Rst_n),
      .d     (Sclk),
      .level (sclk_level),
      .rise  (sclk_rise),
      .fall  (sclk_fall)
   );

   sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk   (Clk),
      .rst_n (Rst_n),
      .d     (MOSI),
      .level (mosi_s),
      .rise  (mosi_rise),
      .fall  (mosi_fall)
   );

   logic unused_ok;
   assign unused_ok = &{1'b0, sclk_level, sclk_fall, mosi_rise, mosi_fall};

   state_e              state;
   logic [DATA_W-1:0]   shreg;
   logic [BIT_W-1:0]    bit_cnt;
   logic [CNT_W-1:0]    word_cnt;
   logic [SETTLE_W-1:0] settle_cnt;

   logic                last_bit;
   logic [BIT_W-1:0]    bit_cnt_nxt;
   logic [CNT_W-1:0]    word_cnt_nxt;
   logic [DATA_W-1:0]   shreg_nxt;
   logic                settled;

   always_comb begin
      last_bit     = 1'b0;
      bit_cnt_nxt  = bit_cnt;
      word_cnt_nxt = word_cnt;
      shreg_nxt    = {shreg[DATA_W-2:0], mosi_s};
      if (sclk_rise) begin
         if (bit_cnt == BIT_W'(DATA_W - 1)) begin
            last_bit    = 1'b1;
            bit_cnt_nxt = '0;
            if (word_cnt != {CNT_W{1'b1}})
               word_cnt_nxt = word_cnt + 1'b1;
         end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
         end
      end
   end

   // The Cs_n synchronizer resets to 1, so its level only reflects the pin once the
   // reset value has been flushed; without this wait a reset during a frame would
   // see a false Cs_n fall and join the frame mid-stream.
   assign settled = (settle_cnt == SETTLE_W'(SETTLE));

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state       <= WAIT_IDLE;
         shreg       <= '0;
         bit_cnt     <= '0;
         word_cnt    <= '0;
         settle_cnt  <= '0;
         data_out    <= '0;
         data_valid  <= 1'b0;
         frame_done  <= 1'b0;
         frame_err   <= 1'b0;
         frame_words <= '0;
      end else begin
         data_valid <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         case (state)
            WAIT_IDLE: begin
               if (!settled)
                  settle_cnt <= settle_cnt + 1'b1;
               else if (cs_level)
                  state <= IDLE;
            end
            IDLE: begin
               if (cs_fall) begin
                  bit_cnt  <= '0;
                  word_cnt <= '0;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               if (sclk_rise) begin
                  shreg    <= shreg_nxt;
                  bit_cnt  <= bit_cnt_nxt;
                  word_cnt <= word_cnt_nxt;
               end
               if (last_bit) begin
                  data_out   <= shreg_nxt;
                  data_valid <= 1'b1;
               end
               // A word finishing in the same cycle as Cs_n rising is counted first.
               if (cs_rise) begin
                  frame_words <= word_cnt_nxt;
                  frame_done  <= 1'b1;
                  frame_err   <= (bit_cnt_nxt != '0);
                  state       <= IDLE;
               end
            end
            default: state <= WAIT_IDLE;
         endcase
      end
   end

   assign dbg_state = state;

endmodule
